// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory responder.
//   ramstate_t  : status reported by the RAM on each cycle.
//   word_t      : one data/address word.
//   arb_state_t : grant state of the responder FSM.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating starvation counter for the memory arbiter.
// Counts dcache completions that happened while an icache request was
// waiting. Clear has priority over increment.
//   clk, rst : clock and synchronous active-high reset
//   inc_i    : count one (ignored once saturated)
//   clr_i    : return to zero
//   cnt_o    : current count, 0..STARVE_MAX
//   sat_o    : count has reached STARVE_MAX
module mem_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              inc_i,
    input  logic                              clr_i,
    output logic [$clog2(STARVE_MAX+1)-1:0]   cnt_o,
    output logic                              sat_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == CNT_W'(STARVE_MAX));
    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the icache and dcache request interfaces.
// Arbitrates between the two caches onto one RAM port. dcache wins ties
// unless it has completed STARVE_MAX transactions in a row while the
// icache was waiting, in which case the icache is granted next.
//   CLK, RST                 : clock, synchronous active-high reset
//   iREN, iaddr              : icache read request and word address
//   iwait, iload             : icache wait (low on completion) and data
//   dREN, dWEN, daddr, dstore: dcache read/write request, address, data
//   dwait, dload             : dcache wait (low on completion) and data
//   ramREN, ramWEN, ramaddr, ramstore : RAM request port
//   ramload, ramstate        : RAM read data and status
//   state_o, starve_cnt_o    : FSM state and starvation count (observation)
//
// Handshake: a requester raises its enable and holds it, with stable
// address/data, until its wait signal is low for one cycle; the wait-low
// cycle is the completion and carries the load data. Dropping the enable
// before that aborts the transaction with no wait pulse. Between any two
// grants there is always one IDLE cycle.
module cache_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              iREN,
    input  logic [WORD_W-1:0]                 iaddr,
    output logic                              iwait,
    output logic [WORD_W-1:0]                 iload,
    input  logic                              dREN,
    input  logic                              dWEN,
    input  logic [WORD_W-1:0]                 daddr,
    input  logic [WORD_W-1:0]                 dstore,
    output logic                              dwait,
    output logic [WORD_W-1:0]                 dload,
    output logic                              ramREN,
    output logic                              ramWEN,
    output logic [WORD_W-1:0]                 ramaddr,
    output logic [WORD_W-1:0]                 ramstore,
    input  logic [WORD_W-1:0]                 ramload,
    input  ramstate_t                         ramstate,
    output arb_state_t                        state_o,
    output logic [$clog2(STARVE_MAX+1)-1:0]   starve_cnt_o
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic cnt_inc;
    logic cnt_clr;
    logic cnt_sat;
    logic d_req;
    logic force_i;
    logic d_is_read;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .cnt_o (starve_cnt_o),
        .sat_o (cnt_sat)
    );

    assign d_req     = dREN | dWEN;
    // Read and write together is treated as a write.
    assign d_is_read = dREN & ~dWEN;
    assign force_i   = cnt_sat & iREN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end

            IGNT: begin
                if (!iREN) begin
                    // Abort: enables stay low, no wait pulse.
                    state_d = IDLE;
                end else begin
                    ramaddr = iaddr;
                    // ERROR: drop the enable for one cycle and retry.
                    ramREN  = (ramstate != ERROR);
                    if (ramstate == ACCESS) begin
                        iwait   = 1'b0;
                        iload   = ramload;
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end
                end
            end

            DGNT: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate != ERROR) begin
                        ramREN = d_is_read;
                        ramWEN = dWEN;
                    end
                    if (ramstate == ACCESS) begin
                        dwait   = 1'b0;
                        dload   = d_is_read ? ramload : '0;
                        state_d = IDLE;
                        // Only completions that made the icache wait count.
                        cnt_inc = iREN;
                        cnt_clr = ~iREN;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;
    import cpu_types_pkg::*;

    localparam int W  = 32;
    localparam int SM = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             iREN;
    logic [W-1:0]     iaddr;
    logic             iwait;
    logic [W-1:0]     iload;
    logic             dREN;
    logic             dWEN;
    logic [W-1:0]     daddr;
    logic [W-1:0]     dstore;
    logic             dwait;
    logic [W-1:0]     dload;
    logic             ramREN;
    logic             ramWEN;
    logic [W-1:0]     ramaddr;
    logic [W-1:0]     ramstore;
    logic [W-1:0]     ramload;
    ramstate_t        ramstate;
    arb_state_t       state_o;
    logic [2:0]       starve_cnt_o;

    int errors = 0;
    int checks = 0;

    cache_mem_responder #(
        .WORD_W     (W),
        .STARVE_MAX (SM)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .iREN         (iREN),
        .iaddr        (iaddr),
        .iwait        (iwait),
        .iload        (iload),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .daddr        (daddr),
        .dstore       (dstore),
        .dwait        (dwait),
        .dload        (dload),
        .ramREN       (ramREN),
        .ramWEN       (ramWEN),
        .ramaddr      (ramaddr),
        .ramstore     (ramstore),
        .ramload      (ramload),
        .ramstate     (ramstate),
        .state_o      (state_o),
        .starve_cnt_o (starve_cnt_o)
    );

    // Clock and reset
    always #5 CLK = ~CLK;

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_req();
        ramload = 32'hFFFF_FFFF;
        tick();
        #1;
        checks++;
        if (state_o !== IDLE || starve_cnt_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_state act=%0d/%0d exp=%0d/0", state_o, starve_cnt_o, IDLE);
        end
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctl act=%b exp=1100", {iwait, dwait, ramREN, ramWEN});
        end
        checks++;
        if (iload !== '0 || dload !== '0 || ramaddr !== '0 || ramstore !== '0) begin
            errors++;
            $display("FAIL reset_data act=%h %h %h %h exp=0", iload, dload, ramaddr, ramstore);
        end
        RST = 1'b0;
        ramload = '0;
    endtask

    task automatic test_icache_only();
        iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
        #1;
        checks++;
        if (state_o !== IDLE || ramREN !== 1'b0 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL ic_idle act=%0d %b %b exp=%0d 0 1", state_o, ramREN, iwait, IDLE);
        end
        for (int k = 0; k < 2; k++) begin
            tick(); ramstate = BUSY; #1;
            checks++;
            if (state_o !== IGNT || ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1 || iload !== '0) begin
                errors++;
                $display("FAIL ic_busy%0d act=%0d %b %h %b %h exp=%0d 1 40 1 0", k, state_o, ramREN, ramaddr, iwait, iload, IGNT);
            end
        end
        tick(); ramstate = ACCESS; ramload = 32'h8C01_0004; #1;
        checks++;
        if (iwait !== 1'b0 || iload !== 32'h8C01_0004 || dwait !== 1'b1 || dload !== '0) begin
            errors++;
            $display("FAIL ic_access act=%b %h %b %h exp=0 8c010004 1 0", iwait, iload, dwait, dload);
        end
        tick(); clear_req(); #1;
        checks++;
        if (state_o !== IDLE || iwait !== 1'b1 || iload !== '0) begin
            errors++;
            $display("FAIL ic_done act=%0d %b %h exp=%0d 1 0", state_o, iwait, iload, IDLE);
        end
    endtask

    task automatic test_simultaneous();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        ramstate = ACCESS; ramload = 32'h1111_2222;
        #1;
        tick(); #1;
        checks++;
        if (state_o !== DGNT || dwait !== 1'b0 || dload !== 32'h1111_2222 || iwait !== 1'b1 || ramaddr !== 32'h100) begin
            errors++;
            $display("FAIL sim_dfirst act=%0d %b %h %b %h exp=%0d 0 11112222 1 100", state_o, dwait, dload, iwait, ramaddr, DGNT);
        end
        tick(); dREN = 1'b0; #1;
        checks++;
        if (state_o !== IDLE || ramREN !== 1'b0 || iwait !== 1'b1 || starve_cnt_o !== 3'd1) begin
            errors++;
            $display("FAIL sim_gap act=%0d %b %b %0d exp=%0d 0 1 1", state_o, ramREN, iwait, starve_cnt_o, IDLE);
        end
        tick(); #1;
        checks++;
        if (state_o !== IGNT || iwait !== 1'b0 || iload !== 32'h1111_2222 || ramaddr !== 32'h44) begin
            errors++;
            $display("FAIL sim_isecond act=%0d %b %h %h exp=%0d 0 11112222 44", state_o, iwait, iload, ramaddr, IGNT);
        end
        tick(); clear_req(); #1;
        checks++;
        if (state_o !== IDLE || starve_cnt_o !== 3'd0) begin
            errors++;
            $display("FAIL sim_done act=%0d %0d exp=%0d 0", state_o, starve_cnt_o, IDLE);
        end
    endtask

    task automatic test_write();
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = FREE;
        #1;
        tick(); ramstate = BUSY; #1;
        checks++;
        if ({ramREN, ramWEN, dwait} !== 3'b011 || ramaddr !== 32'h200 || ramstore !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_busy act=%b %h %h exp=011 200 deadbeef", {ramREN, ramWEN, dwait}, ramaddr, ramstore);
        end
        tick(); ramstate = ACCESS; ramload = 32'hCAFE_F00D; #1;
        checks++;
        if (dwait !== 1'b0 || dload !== '0 || ramWEN !== 1'b1 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL wr_access act=%b %h %b %b exp=0 0 1 1", dwait, dload, ramWEN, iwait);
        end
        tick(); clear_req(); #1;
        checks++;
        if (state_o !== IDLE || ramWEN !== 1'b0 || ramstore !== '0 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL wr_done act=%0d %b %h %b exp=%0d 0 0 1", state_o, ramWEN, ramstore, dwait, IDLE);
        end
    endtask

    task automatic test_starvation();
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300;
        ramstate = ACCESS; ramload = 32'h55;
        #1;
        for (int k = 0; k < SM; k++) begin
            checks++;
            if (state_o !== IDLE || starve_cnt_o !== 3'(k)) begin
                errors++;
                $display("FAIL starve_idle%0d act=%0d %0d exp=%0d %0d", k, state_o, starve_cnt_o, IDLE, k);
            end
            tick(); #1;
            checks++;
            if (state_o !== DGNT || dwait !== 1'b0 || iwait !== 1'b1) begin
                errors++;
                $display("FAIL starve_d%0d act=%0d %b %b exp=%0d 0 1", k, state_o, dwait, iwait, DGNT);
            end
            tick(); #1;
        end
        checks++;
        if (state_o !== IDLE || starve_cnt_o !== 3'd4) begin
            errors++;
            $display("FAIL starve_sat act=%0d %0d exp=%0d 4", state_o, starve_cnt_o, IDLE);
        end
        tick(); #1;
        checks++;
        if (state_o !== IGNT || iwait !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h80) begin
            errors++;
            $display("FAIL starve_force act=%0d %b %b %h exp=%0d 0 1 80", state_o, iwait, dwait, ramaddr, IGNT);
        end
        tick(); clear_req(); #1;
        checks++;
        if (state_o !== IDLE || starve_cnt_o !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear act=%0d %0d exp=%0d 0", state_o, starve_cnt_o, IDLE);
        end
    endtask

    task automatic test_error_retry();
        iREN = 1'b1; iaddr = 32'h90; ramstate = FREE;
        #1;
        tick(); ramstate = ERROR; #1;
        checks++;
        if (state_o !== IGNT || ramREN !== 1'b0 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL err_retry act=%0d %b %b exp=%0d 0 1", state_o, ramREN, iwait, IGNT);
        end
        tick(); ramstate = ACCESS; ramload = 32'h1234; #1;
        checks++;
        if (state_o !== IGNT || ramREN !== 1'b1 || iwait !== 1'b0 || iload !== 32'h1234) begin
            errors++;
            $display("FAIL err_access act=%0d %b %b %h exp=%0d 1 0 1234", state_o, ramREN, iwait, iload, IGNT);
        end
        tick(); clear_req(); #1;
    endtask

    task automatic test_abort();
        dREN = 1'b1; daddr = 32'h310; ramstate = FREE;
        #1;
        tick(); ramstate = BUSY; #1;
        checks++;
        if (state_o !== DGNT || ramREN !== 1'b1 || ramaddr !== 32'h310) begin
            errors++;
            $display("FAIL abort_grant act=%0d %b %h exp=%0d 1 310", state_o, ramREN, ramaddr, DGNT);
        end
        tick(); dREN = 1'b0; ramstate = ACCESS; ramload = 32'h99; #1;
        checks++;
        if ({ramREN, ramWEN, dwait} !== 3'b001 || dload !== '0) begin
            errors++;
            $display("FAIL abort_drop act=%b %h exp=001 0", {ramREN, ramWEN, dwait}, dload);
        end
        tick(); ramstate = FREE; #1;
        checks++;
        if (state_o !== IDLE || dwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle act=%0d %b exp=%0d 1", state_o, dwait, IDLE);
        end
    endtask

    task automatic test_rst_mid();
        dREN = 1'b1; daddr = 32'h400; ramstate = FREE;
        #1;
        tick(); ramstate = BUSY; RST = 1'b1; #1;
        checks++;
        if (state_o !== DGNT || ramREN !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre act=%0d %b exp=%0d 1", state_o, ramREN, DGNT);
        end
        tick(); RST = 1'b0; #1;
        checks++;
        if (state_o !== IDLE || {iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== '0 || dload !== '0) begin
            errors++;
            $display("FAIL rst_abandon act=%0d %b %h %h exp=%0d 1100 0 0", state_o, {iwait, dwait, ramREN, ramWEN}, ramaddr, dload, IDLE);
        end
        tick(); ramstate = ACCESS; ramload = 32'h77; #1;
        checks++;
        if (state_o !== DGNT || ramaddr !== 32'h400 || dwait !== 1'b0 || dload !== 32'h77) begin
            errors++;
            $display("FAIL rst_regrant act=%0d %h %b %h exp=%0d 400 0 77", state_o, ramaddr, dwait, dload, DGNT);
        end
        tick(); clear_req(); #1;
        checks++;
        if (state_o !== IDLE) begin
            errors++;
            $display("FAIL rst_done act=%0d exp=%0d", state_o, IDLE);
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_icache_only();
        test_simultaneous();
        test_write();
        test_starvation();
        test_error_retry();
        test_abort();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the instruction and data cache request interfaces. It accepts icache reads (iREN/iaddr) and dcache reads/writes (dREN/dWEN/daddr/dstore), arbitrates between them, drives a single RAM port, and returns iwait/dwait plus load data. A bounded-starvation rule prevents a continuously busy dcache from locking out instruction fetch.

## Interface
- WORD_W, 32: data and address width.
- STARVE_MAX, 4: maximum consecutive dcache grants while an icache request is pending; the next grant is forced to icache.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- iREN  in  1  icache read request; held until its iwait drops.
- iaddr  in  WORD_W  icache word address.
- iwait  out  1  0 for exactly the cycle iload is valid; otherwise 1.
- iload  out  WORD_W  instruction word; ramload when iwait=0, else 0.
- dREN, dWEN  in  1 each  dcache read/write request; mutually exclusive; held until dwait drops.
- daddr, dstore  in  WORD_W  dcache address and write data.
- dwait  out  1  0 for exactly the completion cycle; otherwise 1.
- dload  out  WORD_W  ramload when dwait=0 on a read, else 0.
- ramREN, ramWEN  out  1 each  RAM enables.
- ramaddr, ramstore  out  WORD_W  RAM address and write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- States: IDLE, IGNT, DGNT.
- IDLE: no RAM enable asserted. Arbitration, evaluated in this order:
  - if (dREN|dWEN) and no force, go to DGNT;
  - else if iREN, go to IGNT;
  - else stay in IDLE.
- Force condition: starve_cnt == STARVE_MAX and iREN=1.
- IGNT:
  - ramREN=1, ramaddr=iaddr.
  - ramstate==ACCESS: iwait=0, iload=ramload, next state IDLE.
- DGNT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - ramstate==ACCESS: dwait=0, dload=ramload when reading, next state IDLE.
- ramstate BUSY or FREE while granted: hold the enables; wait stays 1.
- ramstate ERROR while granted: drop the RAM enables for that cycle and stay in the state (retry); wait stays 1.
- Requester deasserts its enable while granted: abort; RAM enables drop combinationally, next state IDLE, no wait pulse.
- Starvation counter starve_cnt, 0..STARVE_MAX:
  - increments, saturating, on each DGNT completion that has iREN=1;
  - clears on each IGNT completion, and on any DGNT completion with iREN=0.
- Unselected wait is always 1. Unselected load is always 0.
- dREN and dWEN both high is illegal. The block treats it as a write, with ramREN=0.

## Timing
- State and counter are registered. Wait, load and RAM outputs are combinational from state, ramstate and the request inputs (Mealy).
- Minimum transaction: 1 IDLE cycle, then a grant cycle. The wait pulse comes in the first grant cycle that sees ACCESS. A RAM with zero BUSY cycles gives a 2-cycle request-to-data latency.
- Back-to-back requests from the same cache always have at least one IDLE cycle between grants.
- Reset:
  - state=IDLE, starve_cnt=0;
  - iwait=dwait=1, iload=dload=0;
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
- RST asserted mid-transaction: the grant is abandoned at the next edge and no wait pulse is produced. The requester keeps its request and is re-arbitrated after RST falls.
- Simultaneous iREN and dREN in IDLE: dcache wins unless forced.

## Structure
- cpu_types_pkg holds:
  - ramstate_t (FREE, BUSY, ACCESS, ERROR);
  - word_t;
  - new arb_state_t (IDLE, IGNT, DGNT).
- One sub-module, mem_arb_starve_cnt: a saturating counter with inc/clr inputs and a sat output, parameterised by STARVE_MAX.
- The top module contains the FSM and the output mux.

## Test plan
- Icache only: iREN=1, iaddr=0x40, RAM BUSY for 2 cycles then ACCESS with ramload=0x8C010004.
  - Required: iwait=0 only in the ACCESS cycle, iload=0x8C010004, then IDLE.
- Simultaneous requests: iREN=1 and dREN=1, daddr=0x100, zero-latency RAM.
  - Required: dcache served first; icache granted after one IDLE cycle.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF.
  - Required: ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF; dwait=0 for one cycle on ACCESS; dload=0.
- Starvation: iREN held high, dREN re-asserted every transaction, STARVE_MAX=4.
  - Required: exactly 4 dcache completions, then an icache completion; starve_cnt returns to 0.
- ERROR then abort: ERROR during IGNT, then ACCESS.
  - Required: one retry cycle with ramREN=0, then iwait=0.
  - Separately, drop dREN mid-DGNT: RAM enables fall that cycle, no dwait pulse, IDLE next cycle.
- RST high during DGNT, requester holding dREN.
  - Required: the next cycle shows all outputs at reset values; the dcache is re-granted after RST is released.
